bcd_ex3_serial_codec: RTL and testbench
=======================================

# bcd_ex3_serial_codec

Parametrised multi-digit converter between packed BCD and excess-3 code. It generalises the single-digit BCD-to-excess-3 encoder in three ways: it accepts a DIGITS-wide packed word, it converts in either direction under a per-word mode bit, and it flags illegal digits. Conversion runs one digit per clock (least-significant digit first) behind valid/ready handshakes on both sides, so it sits between a digit source (keypad/counter logic) and a display or arithmetic stage.

## Interface
- DIGITS, 4, number of 4-bit digits per word; legal range 1..16
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word (high only in IDLE)
- in_mode  in  1  0 = BCD→excess-3, 1 = excess-3→BCD; sampled at accept
- in_data  in  4*DIGITS  packed input digits; digit i = in_data[4i+3:4i]
- out_valid  out  1  converted word present
- out_ready  in  1  consumer accepts word
- out_data  out  4*DIGITS  packed converted digits
- out_err_mask  out  DIGITS  bit i set = input digit i was illegal
- out_err  out  1  OR of out_err_mask

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data and in_mode, clear the result and mask registers, set digit index=0, and go to CONV.
- CONV: in each cycle, convert the digit at the current index, write the result to out_data digit [index], write the illegal flag to out_err_mask[index], and increment the index. After digit DIGITS-1, go to DONE.
- DONE: out_valid=1. out_data, out_err_mask and out_err are held stable. On out_ready, go to IDLE.
- Mode 0 (BCD→Ex3): a digit d in 0..9 gives d+3 (4-bit result). A digit d in 10..15 is illegal and gives 4'hF.
- Mode 1 (Ex3→BCD): a digit d in 3..12 gives d-3. A digit d in 0..2 or 13..15 is illegal and gives 4'hF.
- All arithmetic is 4-bit. Overflow cannot occur on the legal ranges.
- The index counter is max(1,$clog2(DIGITS)) bits wide. DIGITS=1 is legal: CONV lasts one cycle.
- in_data and in_mode changing after accept have no effect on the word in flight.
- in_valid asserted outside IDLE is ignored; no word is dropped or queued, and the source must hold it.
- out_valid and in_ready are never high together.
- Reset (any state, including mid-CONV) behaviour:
  - State returns to IDLE immediately.
  - The partial word is discarded.
  - Output values during reset: in_ready=1, out_valid=0, out_data=0, out_err_mask=0, out_err=0.

## Timing
- Accept edge = T0. Digits are written on edges T0+1..T0+DIGITS. out_valid rises after edge T0+DIGITS.
- Latency from accept to out_valid is DIGITS cycles.
- DONE→IDLE happens on the edge where out_valid&&out_ready. in_ready is high the following cycle.
- Peak throughput is one word per DIGITS+2 cycles, with out_ready tied high.
- out_data and out_err_mask are registered. During CONV they show partial results and are valid only while out_valid=1.
- Asynchronous reset assertion clears outputs without a clock edge. Deassertion is synchronised externally; the first accept can occur on the first edge after release.

## Test plan
- DIGITS=4, mode 0, in_data=16'h1239 → out_data=16'h456C, out_err_mask=4'b0000, out_err=0, out_valid exactly 4 cycles after accept.
- Mode 1, in_data=16'h456C → out_data=16'h1239, no error. Then mode 1, in_data=16'h3C02 → out_data=16'h09FF, out_err_mask=4'b0011, out_err=1.
- Mode 0, in_data=16'h12A9 → out_data=16'h45FC, out_err_mask=4'b0010, out_err=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new word.
  - Required: out_data held, in_ready=0, new word not taken.
  - After out_ready=1, the new word is accepted one cycle after returning to IDLE.
- Reset mid-CONV: assert rst 2 cycles after accept → outputs zero immediately, in_ready=1. After release, 16'h0000 in mode 0 → 16'h3333, no error.
- DIGITS=1 build: mode 0, in_data=4'h9 → out_data=4'hC after 1 cycle. Mode 0, in_data=4'hF → out_data=4'hF, out_err=1.

Source files
------------

// File: rtl/bcd_ex3_serial_codec.sv
// Multi-digit packed BCD <-> excess-3 converter, one digit per clock (LSD first).
// Illegal input digits map to 4'hF and are flagged per digit in out_err_mask.
module bcd_ex3_serial_codec #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [W-1:0]    data_q;
  logic            mode_q;
  logic [IW-1:0]   idx;
  logic [3:0]      cur_c;
  logic [3:0]      res_c;
  logic            bad_c;

  // Convert the digit at the current index; anything outside the legal range becomes 4'hF.
  always_comb begin
    cur_c = 4'(data_q >> {idx, 2'b00});
    res_c = 4'hF;
    bad_c = 1'b1;
    if (!mode_q) begin
      if (cur_c <= 4'd9) begin
        res_c = cur_c + 4'd3;
        bad_c = 1'b0;
      end
    end else begin
      if ((cur_c >= 4'd3) && (cur_c <= 4'd12)) begin
        res_c = cur_c - 4'd3;
        bad_c = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      data_q       <= '0;
      mode_q       <= 1'b0;
      idx          <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err_mask <= '0;
      out_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q       <= in_data;
            mode_q       <= in_mode;
            idx          <= '0;
            out_data     <= '0;
            out_err_mask <= '0;
            out_err      <= 1'b0;
            in_ready     <= 1'b0;
            state        <= CONV;
          end
        end
        CONV: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
              out_data[4*i +: 4] <= res_c;
              out_err_mask[i]    <= bad_c;
            end
          end
          out_err <= out_err | bad_c;
          if (idx == IW'(DIGITS - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_ex3_serial_codec.sv
// Bench for bcd_ex3_serial_codec: directed cases plus random words against a digit-wise
// arithmetic reference, on a 4-digit instance and a 1-digit instance.
module tb_bcd_ex3_serial_codec;

  localparam int unsigned D = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_mode, out_valid, out_ready, out_err;
  logic [4*D-1:0] in_data, out_data;
  logic [D-1:0]   out_err_mask;

  logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_err;
  logic [3:0] b_in_data, b_out_data;
  logic [0:0] b_out_err_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_ex3_serial_codec #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_mask(out_err_mask), .out_err(out_err)
  );

  bcd_ex3_serial_codec #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_err_mask(b_out_err_mask), .out_err(b_out_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: treat each nibble as an integer and apply the code rules directly.
  function automatic void ref_conv(input logic mode, input logic [63:0] x, input int n,
                                   output logic [63:0] y, output logic [15:0] m);
    int d, r;
    bit legal;
    y = '0;
    m = '0;
    for (int i = 0; i < n; i++) begin
      d     = int'((x >> (4 * i)) % 64'd16);
      legal = mode ? (d >= 3 && d <= 12) : (d <= 9);
      r     = !legal ? 15 : (mode ? d - 3 : d + 3);
      y     = y | (64'(r) << (4 * i));
      m[i]  = !legal;
    end
  endfunction

  // Count edges from accept until out_valid is seen, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic check_word(input string tag, input logic mode, input logic [4*D-1:0] x, input int n);
    logic [63:0] ey;
    logic [15:0] em;
    ref_conv(mode, 64'(x), D, ey, em);
    check({tag, "_latency"}, 64'(n), 64'(D));
    check({tag, "_data"}, 64'(out_data), ey);
    check({tag, "_mask"}, 64'(out_err_mask), 64'(em[D-1:0]));
    check({tag, "_err"}, 64'(out_err), 64'(|em));
    check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
  endtask

  task automatic send(input string tag, input logic mode, input logic [4*D-1:0] x, input int stall);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_mode = mode; in_data = x;
    @(posedge clk); #1;
    in_valid = 1'b0; in_mode = 1'($urandom); in_data = (4*D)'($urandom);
    wait_valid(n);
    check_word(tag, mode, x, n);
    repeat (stall) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic send1(input string tag, input logic mode, input logic [3:0] x);
    int n;
    logic [63:0] ey;
    logic [15:0] em;
    ref_conv(mode, 64'(x), 1, ey, em);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_mode = mode; b_in_data = x;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_data = 4'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!b_out_valid && n < 20);
    check({tag, "_latency"}, 64'(n), 64'd1);
    check({tag, "_data"}, 64'(b_out_data), ey);
    check({tag, "_err"}, 64'(b_out_err), 64'(em[0]));
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check({tag, "_idle_ready"}, 64'(b_in_ready), 64'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_mask", 64'(out_err_mask), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    @(negedge clk); rst = 1'b0;

    send("enc_1239", 1'b0, 16'h1239, 0);
    send("dec_456c", 1'b1, 16'h456C, 0);
    send("dec_3c02", 1'b1, 16'h3C02, 1);
    send("enc_12a9", 1'b0, 16'h12A9, 2);

    // Backpressure: new word held on the input while the result waits in DONE.
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h1239;
    @(posedge clk); #1;
    in_mode = 1'b1; in_data = 16'h456C;
    wait_valid(n);
    check("bp_first_data", 64'(out_data), 64'h456C);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_data", 64'(out_data), 64'h456C);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_back_idle", 64'(in_ready), 64'd1);
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", 64'(in_ready), 64'd0);
    wait_valid(n);
    check_word("bp_second", 1'b1, 16'h456C, n);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a conversion.
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h9876;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_mask", 64'(out_err_mask), 64'd0);
    check("midrst_err", 64'(out_err), 64'd0);
    @(negedge clk); rst = 1'b0;
    send("post_rst_0000", 1'b0, 16'h0000, 0);

    for (int k = 0; k < 30; k++)
      send("rand", 1'($urandom), (4*D)'($urandom), int'($urandom_range(0, 3)));

    send1("d1_9", 1'b0, 4'h9);
    send1("d1_f", 1'b0, 4'hF);
    for (int k = 0; k < 8; k++)
      send1("d1_rand", 1'($urandom), 4'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
